// File: rtl/risc_ctrl_seq_if.sv
// rtl/risc_ctrl_seq_if.sv - control/status bundle between risc_ctrl_seq and the core datapath
//
// Purpose: groups the sequencer's run/decode/memory-handshake inputs and its
//          strobe outputs so the controller and datapath connect through one port.
// Signals:
//   ena, zero, opcode[2:0], mem_rdy, resume   -> into the controller
//   inc_pc, load_acc, load_pc, rd, wr, load_ir,
//   datactl_ena, halt, ir_beat[1:0], bus_err  <- out of the controller
// Modports:
//   master - the controller (risc_ctrl_seq)
//   slave  - the datapath / memory side
interface risc_ctrl_seq_if;
  logic       ena;
  logic       zero;
  logic [2:0] opcode;
  logic       mem_rdy;
  logic       resume;
  logic       inc_pc;
  logic       load_acc;
  logic       load_pc;
  logic       rd;
  logic       wr;
  logic       load_ir;
  logic       datactl_ena;
  logic       halt;
  logic [1:0] ir_beat;
  logic       bus_err;

  modport master (
    input  ena, zero, opcode, mem_rdy, resume,
    output inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt, ir_beat, bus_err
  );

  modport slave (
    output ena, zero, opcode, mem_rdy, resume,
    input  inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt, ir_beat, bus_err
  );
endinterface

// File: rtl/risc_ctrl_seq.sv
// rtl/risc_ctrl_seq.sv - fetch/decode/operand/execute sequencer for the 3-bit-opcode RISC core
//
// Purpose: steps each instruction through a multi-beat IR fetch, decode, PC
//          increment and the opcode-specific operand/execute phase, driving the
//          PC, accumulator, IR, data-bus and memory strobes. All state and
//          outputs change on the falling edge of clk1; outputs are registered
//          and reflect the state being entered.
// Parameters:
//   FETCH_BEATS - bus beats per instruction fetch (1..4)
//   TMO_CYCLES  - wait-state timeout in cycles (1..255), used with WAIT_TIMEOUT_EN
// Ports:
//   clk1 - system clock, falling edge active
//   rst  - synchronous active-high reset
//   bus  - risc_ctrl_seq_if.master (ena, zero, opcode, mem_rdy, resume in;
//          inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt,
//          ir_beat, bus_err out)
// Build option:
//   WAIT_TIMEOUT_EN - when defined, a stalled FETCH/OPF/STW wait of TMO_CYCLES
//                     cycles enters the sticky ERR state (halt=1, bus_err=1).
//                     When undefined, waits hold forever and bus_err stays 0.
module risc_ctrl_seq #(
  parameter int FETCH_BEATS = 2,
  parameter int TMO_CYCLES  = 15
) (
  input logic             clk1,
  input logic             rst,
  risc_ctrl_seq_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_F_INC, S_DEC, S_PC_INC, S_OPF, S_LDACC,
    S_STW, S_STH, S_JUMP, S_SKIP, S_HALTED, S_ERR
  } state_t;

  localparam logic [2:0] OP_HLT  = 3'b000;
  localparam logic [2:0] OP_SKZ  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDD = 3'b011;
  localparam logic [2:0] OP_XORR = 3'b100;
  localparam logic [2:0] OP_LDA  = 3'b101;
  localparam logic [2:0] OP_STO  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  localparam logic [1:0] LAST_BEAT = 2'(FETCH_BEATS - 1);

  generate
    if (FETCH_BEATS < 1 || FETCH_BEATS > 4 || TMO_CYCLES < 1 || TMO_CYCLES > 255) begin : g_bad_cfg
      $error("risc_ctrl_seq: FETCH_BEATS or TMO_CYCLES out of range");
    end
  endgenerate

`ifdef WAIT_TIMEOUT_EN
  localparam bit         ERR_EN   = 1'b1;
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);
`else
  localparam bit         ERR_EN   = 1'b0;
`endif

  state_t     state;
  state_t     nxt_state;
  logic [1:0] beat;
  logic [1:0] nxt_beat;

`ifdef WAIT_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       in_wait;

  assign in_wait = (state == S_FETCH) || (state == S_OPF) || (state == S_STW);
`endif

  // Next-state: beat doubles as the fetch-beat index and the SKIP length counter.
  always_comb begin
    nxt_state = state;
    nxt_beat  = beat;
    case (state)
      S_IDLE:   nxt_state = S_FETCH;
      S_FETCH: begin
        if (bus.mem_rdy) begin
          if (beat == LAST_BEAT) begin
            nxt_beat  = 2'd0;
            nxt_state = S_DEC;
          end else begin
            nxt_beat  = beat + 2'd1;
            nxt_state = S_F_INC;
          end
        end
      end
      S_F_INC:  nxt_state = S_FETCH;
      S_DEC:    nxt_state = S_PC_INC;
      S_PC_INC: begin
        case (bus.opcode)
          OP_HLT:                            nxt_state = S_HALTED;
          OP_JMP:                            nxt_state = S_JUMP;
          OP_ADD, OP_ANDD, OP_XORR, OP_LDA:  nxt_state = S_OPF;
          OP_STO:                            nxt_state = S_STW;
          OP_SKZ:                            nxt_state = bus.zero ? S_SKIP : S_FETCH;
          default:                           nxt_state = S_FETCH;
        endcase
      end
      S_OPF:    if (bus.mem_rdy) nxt_state = S_LDACC;
      S_LDACC:  nxt_state = S_FETCH;
      S_STW:    if (bus.mem_rdy) nxt_state = S_STH;
      S_STH:    nxt_state = S_FETCH;
      S_JUMP:   nxt_state = S_FETCH;
      S_SKIP: begin
        if (beat == LAST_BEAT) begin
          nxt_beat  = 2'd0;
          nxt_state = S_FETCH;
        end else begin
          nxt_beat  = beat + 2'd1;
        end
      end
      S_HALTED: if (bus.resume) nxt_state = S_FETCH;
      S_ERR:    nxt_state = S_ERR;
      default:  nxt_state = S_IDLE;
    endcase
`ifdef WAIT_TIMEOUT_EN
    // The cycle that would bring the count to TMO_CYCLES diverts to ERR.
    if (in_wait && !bus.mem_rdy && wait_cnt == TMO_LAST) begin
      nxt_state = S_ERR;
      nxt_beat  = 2'd0;
    end
`endif
  end

  always_ff @(negedge clk1) begin
    if (rst) begin
      state           <= S_IDLE;
      beat            <= 2'd0;
      bus.inc_pc      <= 1'b0;
      bus.load_acc    <= 1'b0;
      bus.load_pc     <= 1'b0;
      bus.rd          <= 1'b0;
      bus.wr          <= 1'b0;
      bus.load_ir     <= 1'b0;
      bus.datactl_ena <= 1'b0;
      bus.halt        <= 1'b0;
      bus.ir_beat     <= 2'd0;
      bus.bus_err     <= 1'b0;
`ifdef WAIT_TIMEOUT_EN
      wait_cnt        <= 8'd0;
`endif
    end else if (!bus.ena) begin
      // Frozen: state, beat and wait count hold; halt/bus_err keep their value.
      bus.inc_pc      <= 1'b0;
      bus.load_acc    <= 1'b0;
      bus.load_pc     <= 1'b0;
      bus.rd          <= 1'b0;
      bus.wr          <= 1'b0;
      bus.load_ir     <= 1'b0;
      bus.datactl_ena <= 1'b0;
      bus.ir_beat     <= 2'd0;
    end else begin
      state           <= nxt_state;
      beat            <= nxt_beat;
`ifdef WAIT_TIMEOUT_EN
      if (nxt_state != state)
        wait_cnt <= 8'd0;
      else if (in_wait && !bus.mem_rdy)
        wait_cnt <= wait_cnt + 8'd1;
`endif
      // Outputs are the decode of the state being entered.
      bus.inc_pc      <= nxt_state inside {S_F_INC, S_PC_INC, S_SKIP};
      bus.load_acc    <= (nxt_state == S_LDACC);
      bus.load_pc     <= (nxt_state == S_JUMP);
      bus.rd          <= nxt_state inside {S_FETCH, S_OPF, S_LDACC};
      bus.wr          <= (nxt_state == S_STW);
      bus.load_ir     <= (nxt_state == S_FETCH);
      bus.datactl_ena <= nxt_state inside {S_STW, S_STH};
      bus.halt        <= nxt_state inside {S_HALTED, S_ERR};
      bus.ir_beat     <= (nxt_state == S_FETCH) ? nxt_beat : 2'd0;
      bus.bus_err     <= ERR_EN && (nxt_state == S_ERR);
    end
  end

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// tb/tb_risc_ctrl_seq.sv - self-checking bench for risc_ctrl_seq (FETCH_BEATS 2 and 3)
module tb_risc_ctrl_seq;

  localparam int TMO = 4;

  typedef struct packed {
    logic       inc_pc;
    logic       load_acc;
    logic       load_pc;
    logic       rd;
    logic       wr;
    logic       load_ir;
    logic       datactl_ena;
    logic       halt;
    logic [1:0] ir_beat;
    logic       bus_err;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic       ena;
    logic       mem_rdy;
    logic [2:0] opcode;
    logic       zero;
    logic       resume;
  } in_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } step_t;

  logic clk1 = 1'b0;
  logic rst2;
  logic rst3;

  always #5 clk1 = ~clk1;

  risc_ctrl_seq_if bus2 ();
  risc_ctrl_seq_if bus3 ();

  risc_ctrl_seq #(.FETCH_BEATS(2), .TMO_CYCLES(TMO)) u_dut2 (.clk1(clk1), .rst(rst2), .bus(bus2));
  risc_ctrl_seq #(.FETCH_BEATS(3), .TMO_CYCLES(TMO)) u_dut3 (.clk1(clk1), .rst(rst3), .bus(bus3));

  step_t q[$];
  in_t   pend;
  out_t  last_o;
  int    fb;
  int    n_assert = 0;
  int    n_fail   = 0;

  function automatic out_t mk(input bit inc, input bit lacc, input bit lpc, input bit rdv,
                              input bit wrv, input bit lir, input bit dctl, input bit hlt,
                              input logic [1:0] b, input bit berr);
    out_t o;
    o.inc_pc = inc; o.load_acc = lacc; o.load_pc = lpc; o.rd = rdv; o.wr = wrv;
    o.load_ir = lir; o.datactl_ena = dctl; o.halt = hlt; o.ir_beat = b; o.bus_err = berr;
    return o;
  endfunction

  // Expected output vector of each instruction phase.
  function automatic out_t o_fetch(input int b);
    return mk(0, 0, 0, 1, 0, 1, 0, 0, 2'(b), 0);
  endfunction
  function automatic out_t o_zero();  return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic out_t o_inc();   return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic out_t o_opf();   return mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); endfunction
  function automatic out_t o_ldacc(); return mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0); endfunction
  function automatic out_t o_stw();   return mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0); endfunction
  function automatic out_t o_sth();   return mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); endfunction
  function automatic out_t o_jump();  return mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic out_t o_halt();  return mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); endfunction
  function automatic out_t o_err();   return mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1); endfunction

  // Inputs that do not matter for the coming edge are randomised.
  task automatic rand_in();
    pend.rst     = 1'b0;
    pend.ena     = 1'b1;
    pend.mem_rdy = 1'($urandom);
    pend.opcode  = 3'($urandom);
    pend.zero    = 1'($urandom);
    pend.resume  = 1'($urandom);
  endtask

  task automatic push(input out_t o);
    step_t s;
    s.i = pend;
    s.o = o;
    q.push_back(s);
    last_o = o;
    rand_in();
  endtask

  // Clock-enable low: strobes drop, halt/bus_err keep the held state's value.
  task automatic gap(input int n);
    step_t s;
    for (int g = 0; g < n; g++) begin
      s.i        = {1'b0, 1'b0, 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom)};
      s.o        = o_zero();
      s.o.halt   = last_o.halt;
      s.o.bus_err = last_o.bus_err;
      q.push_back(s);
    end
  endtask

  task automatic hold(input out_t o, input int n, input bit may_gap);
    for (int h = 0; h < n; h++) begin
      if (may_gap && ($urandom_range(0, 3) == 0)) gap($urandom_range(1, 3));
      pend.mem_rdy = 1'b0;
      pend.resume  = 1'b0;
      push(o);
    end
  endtask

  task automatic do_reset();
    pend.rst = 1'b1;
    push(o_zero());
  endtask

  task automatic fetch_all(input int fwmax);
    for (int b = 0; b < fb; b++) begin
      push(o_fetch(b));
      hold(o_fetch(b), $urandom_range(0, fwmax), 1'b1);
      pend.mem_rdy = 1'b1;
      if (b < fb - 1) push(o_inc());
    end
    push(o_zero());
    push(o_inc());
  endtask

  // One instruction from its first fetch beat up to the edge back into FETCH.
  task automatic instr(input int op, input bit z, input int fwmax, input int ow,
                       input int hn, input bit hrst);
    int w;
    w = (ow < 0) ? $urandom_range(0, 3) : ow;
    fetch_all(fwmax);
    pend.opcode = 3'(op);
    pend.zero   = z;
    if (op == 0) begin
      push(o_halt());
      hold(o_halt(), hn, 1'b1);
      if (hrst) do_reset();
      else pend.resume = 1'b1;
    end else if (op == 7) begin
      push(o_jump());
    end else if (op == 6) begin
      push(o_stw());
      hold(o_stw(), w, 1'b1);
      pend.mem_rdy = 1'b1;
      push(o_sth());
    end else if (op == 1) begin
      if (z) for (int s = 0; s < fb; s++) push(o_inc());
    end else begin
      push(o_opf());
      hold(o_opf(), w, 1'b1);
      pend.mem_rdy = 1'b1;
      push(o_ldacc());
    end
  endtask

  task automatic run(input int sel);
    out_t obs;
    for (int k = 0; k < q.size(); k++) begin
      @(posedge clk1);
      if (sel == 2) begin
        rst2 = q[k].i.rst; bus2.ena = q[k].i.ena; bus2.mem_rdy = q[k].i.mem_rdy;
        bus2.opcode = q[k].i.opcode; bus2.zero = q[k].i.zero; bus2.resume = q[k].i.resume;
      end else begin
        rst3 = q[k].i.rst; bus3.ena = q[k].i.ena; bus3.mem_rdy = q[k].i.mem_rdy;
        bus3.opcode = q[k].i.opcode; bus3.zero = q[k].i.zero; bus3.resume = q[k].i.resume;
      end
      @(negedge clk1);
      #1;
      if (sel == 2)
        obs = {bus2.inc_pc, bus2.load_acc, bus2.load_pc, bus2.rd, bus2.wr, bus2.load_ir,
               bus2.datactl_ena, bus2.halt, bus2.ir_beat, bus2.bus_err};
      else
        obs = {bus3.inc_pc, bus3.load_acc, bus3.load_pc, bus3.rd, bus3.wr, bus3.load_ir,
               bus3.datactl_ena, bus3.halt, bus3.ir_beat, bus3.bus_err};
      n_assert++;
      assert (obs === q[k].o) else begin
        n_fail++;
        $error("FAIL outputs fb%0d step %0d observed=%b required=%b (inc,lacc,lpc,rd,wr,lir,dctl,halt,beat[1:0],berr)",
               sel, k, obs, q[k].o);
      end
      n_assert++;
      assert ((obs.rd & obs.wr) === 1'b0) else begin
        n_fail++;
        $error("FAIL rd_wr_exclusive fb%0d step %0d observed rd=%b wr=%b required not both", sel, k, obs.rd, obs.wr);
      end
    end
    q.delete();
  endtask

  initial begin
    rst2 = 1'b1;
    rst3 = 1'b1;
    bus2.ena = 1'b0; bus2.zero = 1'b0; bus2.opcode = 3'd0; bus2.mem_rdy = 1'b0; bus2.resume = 1'b0;
    bus3.ena = 1'b0; bus3.zero = 1'b0; bus3.opcode = 3'd0; bus3.mem_rdy = 1'b0; bus3.resume = 1'b0;
    rand_in();
    last_o = o_zero();
    repeat (2) @(negedge clk1);

    // Two-beat fetch core: directed phases, then a random instruction stream.
    fb = 2;
    do_reset();
    instr(5, 0, 0, 0, 0, 0);          // LDA, memory always ready
    instr(6, 0, 0, 3, 0, 0);          // STO with 3 wait cycles
    instr(0, 0, 0, 0, 10, 0);         // HLT held 10 cycles, then resume
    fetch_all(0);                     // LDA: ena low 5 cycles in OPF, then reset
    pend.opcode = 3'd5;
    push(o_opf());
    pend.mem_rdy = 1'b0;
    push(o_opf());
    gap(5);
    pend.mem_rdy = 1'b0;
    push(o_opf());
    do_reset();
    instr(7, 0, 0, 0, 0, 0);          // JMP
    repeat (40) instr($urandom_range(0, 7), 1'($urandom), 3, -1,
                      $urandom_range(0, 4), ($urandom_range(0, 7) == 0));
    run(2);
    rst2 = 1'b1;

    // Three-beat fetch core: SKZ taken and not taken, then random stream.
    fb = 3;
    do_reset();
    instr(1, 1, 0, 0, 0, 0);
    instr(1, 0, 0, 0, 0, 0);
    instr(5, 0, 1, 1, 0, 0);
    repeat (30) instr($urandom_range(0, 7), 1'($urandom), 3, -1,
                      $urandom_range(0, 4), ($urandom_range(0, 7) == 0));
    run(3);
    rst3 = 1'b1;

`ifdef WAIT_TIMEOUT_EN
    // Stalled fetch times out into ERR; resume cannot leave it, reset does.
    fb = 2;
    do_reset();
    push(o_fetch(0));
    hold(o_fetch(0), TMO - 1, 1'b0);
    pend.mem_rdy = 1'b0;
    push(o_err());
    for (int r = 0; r < 4; r++) begin
      pend.resume = 1'b1;
      push(o_err());
    end
    do_reset();
    instr(5, 0, 2, 2, 0, 0);
    push(o_fetch(0));
    run(2);
    rst2 = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
